// File: rtl/rob_recovery_ctrl_pkg.sv
// Shared types and constants for the ROB mispredict-recovery sequencer and its consumers.
`ifndef PREG_IDX_WIDTH
`define PREG_IDX_WIDTH 7
`endif

package rob_recovery_ctrl_pkg;

  localparam int unsigned ARCH_IDX_WIDTH = 5;
  localparam int unsigned PREG_IDX_WIDTH = `PREG_IDX_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } recovery_state_t;

  // One RAT/freelist lane: strobe plus the arch register and physical tag it carries.
  typedef struct packed {
    logic                      en;
    logic [ARCH_IDX_WIDTH-1:0] areg;
    logic [PREG_IDX_WIDTH-1:0] preg;
  } recovery_packet_t;

endpackage

// File: rtl/rob_recovery_ctrl_if.sv
// Branch-resolution, ROB read port, RAT restore and freelist return signals of the recovery sequencer.
interface rob_recovery_ctrl_if #(
  parameter int unsigned ROB_IDX_WIDTH = 6
);
  import rob_recovery_ctrl_pkg::*;

  logic                                 mispredict_valid;
  logic [ROB_IDX_WIDTH-1:0]             mispredict_idx;
  logic [ROB_IDX_WIDTH-1:0]             rob_head;
  logic [ROB_IDX_WIDTH-1:0]             rob_tail;

  logic [1:0][ROB_IDX_WIDTH-1:0]        rob_rd_idx;
  logic [1:0]                           rob_rd_dest_valid;
  logic [1:0][ARCH_IDX_WIDTH-1:0]       rob_rd_arch_dest;
  logic [1:0][PREG_IDX_WIDTH-1:0]       rob_rd_T_new;
  logic [1:0][PREG_IDX_WIDTH-1:0]       rob_rd_T_old;

  logic [1:0]                           rat_restore_en;
  logic [1:0][ARCH_IDX_WIDTH-1:0]       rat_restore_areg;
  logic [1:0][PREG_IDX_WIDTH-1:0]       rat_restore_preg;

  logic [1:0]                           fl_free_en;
  logic [1:0][PREG_IDX_WIDTH-1:0]       fl_free_preg;

  logic                                 rob_tail_set;
  logic [ROB_IDX_WIDTH-1:0]             rob_tail_new;
  logic                                 recovery_busy;
  logic                                 recovery_done;

  modport master (
    input  mispredict_valid, mispredict_idx, rob_head, rob_tail,
    input  rob_rd_dest_valid, rob_rd_arch_dest, rob_rd_T_new, rob_rd_T_old,
    output rob_rd_idx,
    output rat_restore_en, rat_restore_areg, rat_restore_preg,
    output fl_free_en, fl_free_preg,
    output rob_tail_set, rob_tail_new, recovery_busy, recovery_done
  );

  modport slave (
    output mispredict_valid, mispredict_idx, rob_head, rob_tail,
    output rob_rd_dest_valid, rob_rd_arch_dest, rob_rd_T_new, rob_rd_T_old,
    input  rob_rd_idx,
    input  rat_restore_en, rat_restore_areg, rat_restore_preg,
    input  fl_free_en, fl_free_preg,
    input  rob_tail_set, rob_tail_new, recovery_busy, recovery_done
  );

endinterface

// File: rtl/rob_recovery_ctrl_age_compare.sv
// Circular-buffer age compare: a_older when a sits closer to head than b (ages taken modulo ROB size).
module rob_age_compare #(
  parameter int unsigned ROB_IDX_WIDTH = 6
) (
  input  logic [ROB_IDX_WIDTH-1:0] head,
  input  logic [ROB_IDX_WIDTH-1:0] a,
  input  logic [ROB_IDX_WIDTH-1:0] b,
  output logic                     a_older
);

  logic [ROB_IDX_WIDTH-1:0] age_a;
  logic [ROB_IDX_WIDTH-1:0] age_b;

  always_comb begin
    age_a   = a - head;
    age_b   = b - head;
    a_older = (age_a < age_b);
  end

endmodule

// File: rtl/rob_recovery_ctrl.sv
// Mispredict recovery: walks squashed ROB entries youngest-first two per cycle, restoring RAT
// mappings and freeing tags, then truncates the ROB tail to just past the branch.
module rob_recovery_ctrl
  import rob_recovery_ctrl_pkg::*;
#(
  parameter int unsigned ROB_SIZE      = 64,
  parameter int unsigned ROB_IDX_WIDTH = $clog2(ROB_SIZE)
) (
  input logic                 clock,
  input logic                 reset,
  rob_recovery_ctrl_if.master bus
);

  localparam logic [ROB_IDX_WIDTH-1:0] IDX_ONE = ROB_IDX_WIDTH'(1);

  recovery_state_t          state_q, state_d;
  logic [ROB_IDX_WIDTH-1:0] ptr_q, ptr_d;
  logic [ROB_IDX_WIDTH-1:0] remaining_q, remaining_d;
  logic [ROB_IDX_WIDTH-1:0] target_q, target_d;
  logic [ROB_IDX_WIDTH-1:0] accept_remaining;
  logic [ROB_IDX_WIDTH-1:0] step;
  logic                     new_older;
  logic                     extend;
  logic [1:0]               active;

  recovery_packet_t [1:0]          restore;
  logic [1:0][PREG_IDX_WIDTH-1:0]  free_preg;

  rob_age_compare #(
    .ROB_IDX_WIDTH(ROB_IDX_WIDTH)
  ) u_age_compare (
    .head    (bus.rob_head),
    .a       (bus.mispredict_idx),
    .b       (target_q),
    .a_older (new_older)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      target_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      target_q    <= target_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    remaining_d      = remaining_q;
    target_d         = target_q;
    active           = '0;
    step             = '0;
    restore          = '0;
    free_preg        = '0;
    bus.rob_rd_idx   = '0;
    bus.rob_tail_set = 1'b0;
    bus.rob_tail_new = '0;
    bus.recovery_busy = 1'b0;
    bus.recovery_done = 1'b0;
    extend           = bus.mispredict_valid && new_older;
    accept_remaining = bus.rob_tail - bus.mispredict_idx - IDX_ONE;

    unique case (state_q)
      IDLE: begin
        if (bus.mispredict_valid) begin
          target_d    = bus.mispredict_idx;
          ptr_d       = bus.rob_tail - IDX_ONE;
          remaining_d = accept_remaining;
          state_d     = (accept_remaining == '0) ? DONE : WALK;
        end
      end

      WALK: begin
        bus.recovery_busy = 1'b1;
        bus.rob_rd_idx[0] = ptr_q;
        bus.rob_rd_idx[1] = ptr_q - IDX_ONE;
        active[0]         = (remaining_q != '0);
        active[1]         = (remaining_q > IDX_ONE);
        for (int unsigned k = 0; k < 2; k++) begin
          if (active[k] && bus.rob_rd_dest_valid[k]) begin
            restore[k].en   = 1'b1;
            restore[k].areg = bus.rob_rd_arch_dest[k];
            restore[k].preg = bus.rob_rd_T_old[k];
            free_preg[k]    = bus.rob_rd_T_new[k];
          end
        end
        step        = ROB_IDX_WIDTH'(active[0]) + ROB_IDX_WIDTH'(active[1]);
        ptr_d       = ptr_q - step;
        remaining_d = remaining_q - step;
        // An older branch appends the entries between the two branches behind the current walk.
        if (extend) begin
          target_d    = bus.mispredict_idx;
          remaining_d = remaining_q - step + (target_q - bus.mispredict_idx);
        end
        state_d = (remaining_d == '0) ? DONE : WALK;
      end

      DONE: begin
        bus.recovery_busy = 1'b1;
        // ptr_q already equals the old target here, so an extension resumes walking from it.
        if (extend) begin
          target_d    = bus.mispredict_idx;
          remaining_d = target_q - bus.mispredict_idx;
          state_d     = WALK;
        end else begin
          bus.rob_tail_set  = 1'b1;
          bus.rob_tail_new  = target_q + IDX_ONE;
          bus.recovery_done = 1'b1;
          state_d           = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      bus.rat_restore_en[k]   = restore[k].en;
      bus.rat_restore_areg[k] = restore[k].areg;
      bus.rat_restore_preg[k] = restore[k].preg;
      bus.fl_free_en[k]       = restore[k].en;
      bus.fl_free_preg[k]     = free_preg[k];
    end
  end

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Self-checking bench for rob_recovery_ctrl: directed vector table plus randomized recoveries
// checked against a queue-based model of the squashed-entry walk.
module tb_rob_recovery_ctrl;
  import rob_recovery_ctrl_pkg::*;

  localparam int unsigned RS   = 64;
  localparam int unsigned IW   = 6;
  localparam int          MASK = 63;

  typedef struct {
    int head, tail, idx;
    int ext1_at, ext1_idx, ext2_at, ext2_idx;
    int reset_at;
    int exp_n, exp_lat, exp_tail_new;
  } vec_t;

  logic clock = 1'b0;
  logic reset;

  rob_recovery_ctrl_if #(.ROB_IDX_WIDTH(IW)) bus ();

  rob_recovery_ctrl #(
    .ROB_SIZE      (RS),
    .ROB_IDX_WIDTH (IW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic                      rob_dv   [RS];
  logic [ARCH_IDX_WIDTH-1:0] rob_areg [RS];
  logic [PREG_IDX_WIDTH-1:0] rob_tnew [RS];
  logic [PREG_IDX_WIDTH-1:0] rob_told [RS];

  int rat [32];
  int n_err = 0;
  int n_chk = 0;
  int cur_case = 0;
  int freed_cnt;
  int freed_sum;
  vec_t vecs [8];

  // ROB read port: combinational read data, same cycle as the address.
  always_comb begin
    bus.rob_rd_dest_valid[0] = rob_dv[bus.rob_rd_idx[0]];
    bus.rob_rd_dest_valid[1] = rob_dv[bus.rob_rd_idx[1]];
    bus.rob_rd_arch_dest[0]  = rob_areg[bus.rob_rd_idx[0]];
    bus.rob_rd_arch_dest[1]  = rob_areg[bus.rob_rd_idx[1]];
    bus.rob_rd_T_new[0]      = rob_tnew[bus.rob_rd_idx[0]];
    bus.rob_rd_T_new[1]      = rob_tnew[bus.rob_rd_idx[1]];
    bus.rob_rd_T_old[0]      = rob_told[bus.rob_rd_idx[0]];
    bus.rob_rd_T_old[1]      = rob_told[bus.rob_rd_idx[1]];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL case %0d %s: got %0d expected %0d at %0t", cur_case, name, act, exp, $time);
    end
  endtask

  function automatic bit older(input int head, input int a, input int b);
    return ((a - head) & MASK) < ((b - head) & MASK);
  endfunction

  task automatic fill_rob();
    for (int i = 0; i < int'(RS); i++) begin
      rob_dv[i]   = ($urandom_range(0, 3) != 0);
      rob_areg[i] = rob_dv[i] ? ARCH_IDX_WIDTH'($urandom_range(1, 31)) : '0;
      rob_tnew[i] = PREG_IDX_WIDTH'($urandom_range(0, 127));
      rob_told[i] = PREG_IDX_WIDTH'($urandom_range(0, 127));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},     int'(bus.recovery_busy), 0);
    chk({tag, "_done"},     int'(bus.recovery_done), 0);
    chk({tag, "_tail_set"}, int'(bus.rob_tail_set), 0);
    chk({tag, "_tail_new"}, int'(bus.rob_tail_new), 0);
    chk({tag, "_rd_idx"},   int'(bus.rob_rd_idx), 0);
    chk({tag, "_rat_en"},   int'(bus.rat_restore_en), 0);
    chk({tag, "_fl_en"},    int'(bus.fl_free_en), 0);
  endtask

  task automatic run_case(input vec_t v);
    int q[$];
    int walked[$];
    int exp_rat [32];
    int target, lat, tail_new, ext_idx, e, n, bad, exp_cnt, exp_sum;
    bit ext_now, finished, aborted;
    target   = v.idx;
    lat      = -1;
    tail_new = -1;
    finished = 1'b0;
    aborted  = 1'b0;
    freed_cnt = 0;
    freed_sum = 0;
    for (int a = 0; a < 32; a++) rat[a] = a;
    for (int i = 1; i <= ((v.tail - v.idx - 1) & MASK); i++) q.push_back((v.tail - i) & MASK);

    @(negedge clock);
    bus.rob_head         = IW'(v.head);
    bus.rob_tail         = IW'(v.tail);
    bus.mispredict_valid = 1'b1;
    bus.mispredict_idx   = IW'(v.idx);
    #1;
    chk("accept_busy", int'(bus.recovery_busy), 0);
    chk("accept_rat_en", int'(bus.rat_restore_en), 0);

    for (int c = 1; c <= 100 && !finished && !aborted; c++) begin
      @(negedge clock);
      ext_now = 1'b0;
      ext_idx = 0;
      if (c == v.ext1_at) begin
        ext_now = 1'b1;
        ext_idx = v.ext1_idx;
      end else if (c == v.ext2_at) begin
        ext_now = 1'b1;
        ext_idx = v.ext2_idx;
      end
      bus.mispredict_valid = ext_now;
      bus.mispredict_idx   = IW'(ext_idx);
      if (c == v.reset_at) begin
        reset = 1'b1;
        #1;
        check_all_zero("midwalk_reset");
        aborted = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        bus.mispredict_valid = 1'b0;
      end else begin
        #1;
        if (q.size() != 0) begin
          chk("walk_busy", int'(bus.recovery_busy), 1);
          chk("walk_done", int'(bus.recovery_done), 0);
          chk("walk_tail_set", int'(bus.rob_tail_set), 0);
          chk("rd_idx0", int'(bus.rob_rd_idx[0]), q[0]);
          chk("rd_idx1", int'(bus.rob_rd_idx[1]), (q[0] - 1) & MASK);
          for (int k = 0; k < 2; k++) begin
            if (k < q.size()) begin
              e = q[k];
              chk("restore_en", int'(bus.rat_restore_en[k]), int'(rob_dv[e]));
              chk("free_en", int'(bus.fl_free_en[k]), int'(rob_dv[e]));
              if (rob_dv[e]) begin
                chk("restore_areg", int'(bus.rat_restore_areg[k]), int'(rob_areg[e]));
                chk("restore_preg", int'(bus.rat_restore_preg[k]), int'(rob_told[e]));
                chk("free_preg", int'(bus.fl_free_preg[k]), int'(rob_tnew[e]));
              end
            end else begin
              chk("idle_slot_restore_en", int'(bus.rat_restore_en[k]), 0);
              chk("idle_slot_free_en", int'(bus.fl_free_en[k]), 0);
            end
          end
          // The RAT applies slot 0 first and slot 1 (older) last.
          for (int k = 0; k < 2; k++) begin
            if (bus.rat_restore_en[k]) rat[bus.rat_restore_areg[k]] = int'(bus.rat_restore_preg[k]);
            if (bus.fl_free_en[k]) begin
              freed_cnt++;
              freed_sum += int'(bus.fl_free_preg[k]);
            end
          end
          n = (q.size() < 2) ? q.size() : 2;
          repeat (n) walked.push_back(q.pop_front());
          if (ext_now && older(v.head, ext_idx, target)) begin
            for (int i = target; i != ext_idx; i = (i - 1) & MASK) q.push_back(i);
            target = ext_idx;
          end
        end else if (ext_now && older(v.head, ext_idx, target)) begin
          chk("done_suppressed", int'(bus.recovery_done), 0);
          chk("tail_set_suppressed", int'(bus.rob_tail_set), 0);
          chk("done_busy", int'(bus.recovery_busy), 1);
          for (int i = target; i != ext_idx; i = (i - 1) & MASK) q.push_back(i);
          target = ext_idx;
        end else begin
          chk("done_pulse", int'(bus.recovery_done), 1);
          chk("tail_set", int'(bus.rob_tail_set), 1);
          chk("done_busy", int'(bus.recovery_busy), 1);
          chk("tail_new_model", int'(bus.rob_tail_new), (target + 1) & MASK);
          chk("done_rat_en", int'(bus.rat_restore_en), 0);
          lat      = c;
          tail_new = int'(bus.rob_tail_new);
          finished = 1'b1;
        end
      end
    end

    if (!aborted) begin
      if (!finished) chk("timeout_no_done", 0, 1);
      @(negedge clock);
      bus.mispredict_valid = 1'b0;
      #1;
      chk("idle_busy", int'(bus.recovery_busy), 0);
      chk("idle_done", int'(bus.recovery_done), 0);
      if (v.exp_n >= 0)        chk("squash_count", walked.size(), v.exp_n);
      if (v.exp_lat >= 0)      chk("latency", lat, v.exp_lat);
      if (v.exp_tail_new >= 0) chk("tail_new", tail_new, v.exp_tail_new);
      // Final RAT: each squashed arch dest maps back to the T_old of its oldest squashed writer.
      for (int a = 0; a < 32; a++) exp_rat[a] = a;
      exp_cnt = 0;
      exp_sum = 0;
      foreach (walked[i]) begin
        if (rob_dv[walked[i]]) begin
          exp_rat[rob_areg[walked[i]]] = int'(rob_told[walked[i]]);
          exp_cnt++;
          exp_sum += int'(rob_tnew[walked[i]]);
        end
      end
      bad = 0;
      for (int a = 0; a < 32; a++) if (rat[a] != exp_rat[a]) bad++;
      chk("rat_final_mismatches", bad, 0);
      chk("freed_count", freed_cnt, exp_cnt);
      chk("freed_tag_sum", freed_sum, exp_sum);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                = 1'b1;
    bus.mispredict_valid = 1'b0;
    bus.mispredict_idx   = '0;
    bus.rob_head         = '0;
    bus.rob_tail         = '0;
    fill_rob();

    //          head tail idx e1at e1idx e2at e2idx rst  n   lat tail_new
    vecs[0] = '{0,   10,  3,  -1,  0,   -1,  0,   -1,  6,  4,  4};
    vecs[1] = '{60,  2,   62, -1,  0,   -1,  0,   -1,  3,  3,  63};
    vecs[2] = '{0,   20,  19, -1,  0,   -1,  0,   -1,  0,  1,  20};
    vecs[3] = '{5,   5,   5,  -1,  0,   -1,  0,   -1,  63, 33, 6};
    vecs[4] = '{63,  63,  0,  -1,  0,   -1,  0,   -1,  62, 32, 1};
    vecs[5] = '{0,   30,  20, 2,   25,  3,   12,  -1,  17, 10, 13};
    vecs[6] = '{0,   10,  3,  4,   1,   -1,  0,   -1,  8,  6,  2};
    vecs[7] = '{0,   40,  0,  -1,  0,   -1,  0,   5,   -1, -1, -1};

    repeat (2) @(negedge clock);
    #1;
    check_all_zero("reset_state");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      cur_case = i;
      fill_rob();
      if (i == 0) begin
        rob_dv[9] = 1'b1; rob_areg[9] = 5'd7; rob_told[9] = 7'd40;
        rob_dv[8] = 1'b1; rob_areg[8] = 5'd7; rob_told[8] = 7'd33;
        rob_dv[7] = 1'b0; rob_areg[7] = 5'd0;
        rob_dv[6] = 1'b1; rob_areg[6] = 5'd6;
        rob_dv[5] = 1'b1; rob_areg[5] = 5'd5;
        rob_dv[4] = 1'b1; rob_areg[4] = 5'd4;
      end
      run_case(vecs[i]);
      if (i == 0) chk("conflict_x7_older_wins", rat[7], 33);
    end

    for (int r = 0; r < 24; r++) begin
      vec_t v;
      int occ, n;
      cur_case = 100 + r;
      v.head = int'($urandom_range(0, 63));
      v.tail = int'($urandom_range(0, 63));
      occ = (v.tail - v.head) & MASK;
      if (occ == 0) occ = int'(RS);
      v.idx = (v.head + int'($urandom_range(0, occ - 1))) & MASK;
      n = (v.tail - v.idx - 1) & MASK;
      v.ext2_at  = -1;
      v.ext2_idx = 0;
      v.reset_at = -1;
      if ($urandom_range(0, 1) == 1) begin
        v.ext1_at      = int'($urandom_range(1, (n + 1) / 2 + 1));
        v.ext1_idx     = (v.head + int'($urandom_range(0, occ - 1))) & MASK;
        v.exp_n        = -1;
        v.exp_lat      = -1;
        v.exp_tail_new = -1;
      end else begin
        v.ext1_at      = -1;
        v.ext1_idx     = 0;
        v.exp_n        = n;
        v.exp_lat      = (n + 1) / 2 + 1;
        v.exp_tail_new = (v.idx + 1) & MASK;
      end
      fill_rob();
      run_case(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
